// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared defaults and helpers for the pipeline hazard controller.
// Forwarding is selected at build time with the PIPE_FWD_EN macro.
package pipe_hazard_ctrl_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int RA_W_DEF    = 5;
    localparam int FLUSH_CNT_W = 3;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline stages (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
);
    logic [XLEN-1:0] pc_o;
    logic            fetch_valid_o;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic [RA_W-1:0] dec_rs1_i;
    logic [RA_W-1:0] dec_rs2_i;
    logic            dec_use1_i;
    logic            dec_use2_i;
    logic            ex_valid_i;
    logic            ex_we_i;
    logic            ex_load_i;
    logic [RA_W-1:0] ex_rd_i;
    logic            wb_valid_i;
    logic            wb_we_i;
    logic [RA_W-1:0] wb_rd_i;
    logic [XLEN-1:0] wb_data_i;
    logic [XLEN-1:0] rs1_raw_i;
    logic [XLEN-1:0] rs2_raw_i;
    logic [XLEN-1:0] rs1_o;
    logic [XLEN-1:0] rs2_o;
    logic            stall_o;
    logic            bubble_o;

    modport master (
        input  pc_o, fetch_valid_o, rs1_o, rs2_o, stall_o, bubble_o,
        output redirect_i, redirect_pc_i, dec_rs1_i, dec_rs2_i, dec_use1_i, dec_use2_i,
               ex_valid_i, ex_we_i, ex_load_i, ex_rd_i, wb_valid_i, wb_we_i, wb_rd_i,
               wb_data_i, rs1_raw_i, rs2_raw_i
    );

    modport slave (
        output pc_o, fetch_valid_o, rs1_o, rs2_o, stall_o, bubble_o,
        input  redirect_i, redirect_pc_i, dec_rs1_i, dec_rs2_i, dec_use1_i, dec_use2_i,
               ex_valid_i, ex_we_i, ex_load_i, ex_rd_i, wb_valid_i, wb_we_i, wb_rd_i,
               wb_data_i, rs1_raw_i, rs2_raw_i
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// One operand's priority match: live write-back port, then history entry 0 upward, else raw.
module pipe_hazard_ctrl_fwd_sel
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int RA_W      = RA_W_DEF,
    parameter int FWD_DEPTH = 2
) (
    input  logic [RA_W-1:0]                 rs_i,
    input  logic                            wb_v_i,
    input  logic [RA_W-1:0]                 wb_rd_i,
    input  logic [XLEN-1:0]                 wb_data_i,
    input  logic [FWD_DEPTH-1:0]            hist_v_i,
    input  logic [FWD_DEPTH-1:0][RA_W-1:0]  hist_rd_i,
    input  logic [FWD_DEPTH-1:0][XLEN-1:0]  hist_data_i,
    input  logic [XLEN-1:0]                 raw_i,
    output logic                            hit_o,
    output logic [XLEN-1:0]                 data_o
);

    // Oldest entry is visited first so younger matches overwrite it; x0 never matches.
    always_comb begin
        hit_o  = 1'b0;
        data_o = raw_i;
        if (rs_i != '0) begin
            for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
                if (hist_v_i[i] && (hist_rd_i[i] == rs_i)) begin
                    hit_o  = 1'b1;
                    data_o = hist_data_i[i];
                end
            end
            if (wb_v_i && (wb_rd_i == rs_i)) begin
                hit_o  = 1'b1;
                data_o = wb_data_i;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: fetch PC, redirect flush, load-use stall and write-back forwarding.
// Define PIPE_FWD_EN for forwarding; without it every pending RAW dependency stalls instead.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int              XLEN        = XLEN_DEF,
    parameter int              RA_W        = RA_W_DEF,
    parameter logic [XLEN-1:0] START_ADDR  = '0,
    parameter int              FWD_DEPTH   = 2,
    parameter int              FLUSH_SLOTS = 2,
    parameter int              LOAD_LAT    = 1
) (
    input logic              p_clk,
    input logic              rst_n,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int SC_W = cnt_width(LOAD_LAT - 1);

    logic [XLEN-1:0]                pc_q, pc_d;
    logic [FLUSH_CNT_W-1:0]         flush_cnt_q, flush_cnt_d;
    logic [SC_W-1:0]                stall_cnt_q, stall_cnt_d;
    logic [FWD_DEPTH-1:0]           hist_v_q, hist_v_d;
    logic [FWD_DEPTH-1:0][RA_W-1:0] hist_rd_q, hist_rd_d;
    logic [FWD_DEPTH-1:0][XLEN-1:0] hist_data_q, hist_data_d;

    logic            wb_wr, load_hit, raw_hit, dep_stall, stall, bubble;
    logic            rs1_hist_hit, rs2_hist_hit;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;

    assign wb_wr    = bus.wb_valid_i & bus.wb_we_i;
    assign load_hit = bus.ex_valid_i & bus.ex_load_i & bus.ex_we_i & (bus.ex_rd_i != '0) &
                      ((bus.dec_use1_i & (bus.ex_rd_i == bus.dec_rs1_i)) |
                       (bus.dec_use2_i & (bus.ex_rd_i == bus.dec_rs2_i)));

    pipe_hazard_ctrl_fwd_sel #(.XLEN(XLEN), .RA_W(RA_W), .FWD_DEPTH(FWD_DEPTH)) u_fwd_rs1 (
        .rs_i(bus.dec_rs1_i), .wb_v_i(wb_wr), .wb_rd_i(bus.wb_rd_i), .wb_data_i(bus.wb_data_i),
        .hist_v_i(hist_v_q), .hist_rd_i(hist_rd_q), .hist_data_i(hist_data_q),
        .raw_i(bus.rs1_raw_i), .hit_o(rs1_hist_hit), .data_o(rs1_fwd)
    );

    pipe_hazard_ctrl_fwd_sel #(.XLEN(XLEN), .RA_W(RA_W), .FWD_DEPTH(FWD_DEPTH)) u_fwd_rs2 (
        .rs_i(bus.dec_rs2_i), .wb_v_i(wb_wr), .wb_rd_i(bus.wb_rd_i), .wb_data_i(bus.wb_data_i),
        .hist_v_i(hist_v_q), .hist_rd_i(hist_rd_q), .hist_data_i(hist_data_q),
        .raw_i(bus.rs2_raw_i), .hit_o(rs2_hist_hit), .data_o(rs2_fwd)
    );

`ifdef PIPE_FWD_EN
    logic unused_fwd_hits;
    assign unused_fwd_hits = rs1_hist_hit | rs2_hist_hit;
    assign raw_hit   = 1'b0;
    assign bus.rs1_o = rs1_fwd;
    assign bus.rs2_o = rs2_fwd;
`else
    logic ex_wr, unused_fwd_data;
    assign ex_wr   = bus.ex_valid_i & bus.ex_we_i;
    assign raw_hit = (bus.dec_use1_i & (bus.dec_rs1_i != '0) &
                      (rs1_hist_hit | (ex_wr & (bus.ex_rd_i == bus.dec_rs1_i)))) |
                     (bus.dec_use2_i & (bus.dec_rs2_i != '0) &
                      (rs2_hist_hit | (ex_wr & (bus.ex_rd_i == bus.dec_rs2_i))));
    assign unused_fwd_data = ^{rs1_fwd, rs2_fwd};
    assign bus.rs1_o = bus.rs1_raw_i;
    assign bus.rs2_o = bus.rs2_raw_i;
`endif

    // A redirect kills the stalled instruction, so it drops the stall but still bubbles execute.
    always_comb begin
        dep_stall = load_hit | raw_hit | (stall_cnt_q != '0);
        stall     = bus.redirect_i ? 1'b0 : dep_stall;
        bubble    = bus.redirect_i ? 1'b1 : dep_stall;

        pc_d = pc_q + XLEN'(4);
        if (bus.redirect_i) begin
            pc_d = {bus.redirect_pc_i[XLEN-1:2], 2'b00};
        end else if (stall) begin
            pc_d = pc_q;
        end

        flush_cnt_d = flush_cnt_q;
        if (bus.redirect_i) begin
            flush_cnt_d = FLUSH_CNT_W'(FLUSH_SLOTS);
        end else if (flush_cnt_q != '0) begin
            flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
        end

        stall_cnt_d = stall_cnt_q;
        if (bus.redirect_i) begin
            stall_cnt_d = '0;
        end else if (load_hit) begin
            stall_cnt_d = SC_W'(LOAD_LAT - 1);
        end else if (stall_cnt_q != '0) begin
            stall_cnt_d = stall_cnt_q - SC_W'(1);
        end

        hist_v_d       = hist_v_q;
        hist_rd_d      = hist_rd_q;
        hist_data_d    = hist_data_q;
        hist_v_d[0]    = wb_wr;
        hist_rd_d[0]   = bus.wb_rd_i;
        hist_data_d[0] = bus.wb_data_i;
        for (int i = 1; i < FWD_DEPTH; i++) begin
            hist_v_d[i]    = hist_v_q[i-1];
            hist_rd_d[i]   = hist_rd_q[i-1];
            hist_data_d[i] = hist_data_q[i-1];
        end
    end

    always_ff @(posedge p_clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= START_ADDR;
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
            hist_v_q    <= '0;
            hist_rd_q   <= '0;
            hist_data_q <= '0;
        end else begin
            pc_q        <= pc_d;
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            hist_v_q    <= hist_v_d;
            hist_rd_q   <= hist_rd_d;
            hist_data_q <= hist_data_d;
        end
    end

    assign bus.pc_o          = pc_q;
    assign bus.fetch_valid_o = (flush_cnt_q == '0);
    assign bus.stall_o       = stall;
    assign bus.bubble_o      = bubble;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a behavioural model queues expectations, a monitor checks them.
// Follows the PIPE_FWD_EN build macro the same way as the design.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int          XLEN        = 32;
    localparam int          RA_W        = 5;
    localparam int          FWD_DEPTH   = 2;
    localparam int          FLUSH_SLOTS = 2;
    localparam int          LOAD_LAT    = 2;
    localparam logic [31:0] START_ADDR  = 32'h0000_0000;

    typedef struct packed {
        logic        redirect;
        logic [31:0] redirect_pc;
        logic [4:0]  rs1, rs2;
        logic        use1, use2;
        logic        ex_valid, ex_we, ex_load;
        logic [4:0]  ex_rd;
        logic        wb_valid, wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data, rs1_raw, rs2_raw;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        fv, stall, bubble;
        logic [31:0] rs1, rs2;
    } exp_t;

    typedef struct packed {
        logic        v;
        logic [4:0]  rd;
        logic [31:0] data;
    } hist_t;

    logic  p_clk = 1'b0;
    logic  rst_n = 1'b0;
    exp_t  exp_q[$];
    int    tests_run    = 0;
    int    tests_failed = 0;

    logic [31:0] m_pc;
    int          m_flush, m_stall;
    hist_t       m_hist[$];

    always #5 p_clk = ~p_clk;

    pipe_hazard_ctrl_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

    pipe_hazard_ctrl #(
        .XLEN(XLEN), .RA_W(RA_W), .START_ADDR(START_ADDR), .FWD_DEPTH(FWD_DEPTH),
        .FLUSH_SLOTS(FLUSH_SLOTS), .LOAD_LAT(LOAD_LAT)
    ) dut (
        .p_clk(p_clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic model_reset();
        m_pc    = START_ADDR;
        m_flush = 0;
        m_stall = 0;
        m_hist.delete();
        for (int i = 0; i < FWD_DEPTH; i++) m_hist.push_back('0);
    endtask

    function automatic logic [31:0] resolve(input stim_t s, input logic [4:0] rs, input logic [31:0] raw);
        if (rs == 5'd0) return raw;
        if (s.wb_valid && s.wb_we && s.wb_rd == rs) return s.wb_data;
        foreach (m_hist[i]) if (m_hist[i].v && m_hist[i].rd == rs) return m_hist[i].data;
        return raw;
    endfunction

    function automatic bit writer_pending(input stim_t s, input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        if (s.ex_valid && s.ex_we && s.ex_rd == rs) return 1'b1;
        if (s.wb_valid && s.wb_we && s.wb_rd == rs) return 1'b1;
        foreach (m_hist[i]) if (m_hist[i].v && m_hist[i].rd == rs) return 1'b1;
        return 1'b0;
    endfunction

    task automatic applyStimulus(input stim_t s, input logic rst_val);
        exp_t e;
        bit   hit, dep;
        @(posedge p_clk);
        #1;
        rst_n             = rst_val;
        bus.redirect_i    = s.redirect;
        bus.redirect_pc_i = s.redirect_pc;
        bus.dec_rs1_i     = s.rs1;
        bus.dec_rs2_i     = s.rs2;
        bus.dec_use1_i    = s.use1;
        bus.dec_use2_i    = s.use2;
        bus.ex_valid_i    = s.ex_valid;
        bus.ex_we_i       = s.ex_we;
        bus.ex_load_i     = s.ex_load;
        bus.ex_rd_i       = s.ex_rd;
        bus.wb_valid_i    = s.wb_valid;
        bus.wb_we_i       = s.wb_we;
        bus.wb_rd_i       = s.wb_rd;
        bus.wb_data_i     = s.wb_data;
        bus.rs1_raw_i     = s.rs1_raw;
        bus.rs2_raw_i     = s.rs2_raw;
        if (!rst_val) model_reset();

        hit = s.ex_valid && s.ex_load && s.ex_we && s.ex_rd != 5'd0 &&
              ((s.use1 && s.ex_rd == s.rs1) || (s.use2 && s.ex_rd == s.rs2));
        dep = hit || (m_stall > 0);
`ifdef PIPE_FWD_EN
        e.rs1 = resolve(s, s.rs1, s.rs1_raw);
        e.rs2 = resolve(s, s.rs2, s.rs2_raw);
`else
        dep = dep || (s.use1 && writer_pending(s, s.rs1)) || (s.use2 && writer_pending(s, s.rs2));
        e.rs1 = s.rs1_raw;
        e.rs2 = s.rs2_raw;
`endif
        e.stall  = s.redirect ? 1'b0 : dep;
        e.bubble = s.redirect ? 1'b1 : dep;
        e.pc     = m_pc;
        e.fv     = (m_flush == 0);
        exp_q.push_back(e);

        if (rst_val) begin
            if (s.redirect)     m_pc = s.redirect_pc & ~32'h3;
            else if (!e.stall)  m_pc = m_pc + 32'd4;
            m_flush = s.redirect ? FLUSH_SLOTS : (m_flush > 0 ? m_flush - 1 : 0);
            m_stall = s.redirect ? 0 : (hit ? LOAD_LAT - 1 : (m_stall > 0 ? m_stall - 1 : 0));
            m_hist.push_front('{v: s.wb_valid && s.wb_we, rd: s.wb_rd, data: s.wb_data});
            void'(m_hist.pop_back());
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: the DUT presents a result every cycle, checked half a period after it was driven.
    initial begin
        exp_t e;
        forever begin
            @(negedge p_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("pc_o",          bus.pc_o,                   e.pc);
                checkOutput("fetch_valid_o", {31'd0, bus.fetch_valid_o}, {31'd0, e.fv});
                checkOutput("stall_o",       {31'd0, bus.stall_o},       {31'd0, e.stall});
                checkOutput("bubble_o",      {31'd0, bus.bubble_o},      {31'd0, e.bubble});
                checkOutput("rs1_o",         bus.rs1_o,                  e.rs1);
                checkOutput("rs2_o",         bus.rs2_o,                  e.rs2);
            end
        end
    end

    function automatic stim_t rnd_stim();
        stim_t s;
        s.redirect    = ($urandom_range(0, 9) == 0);
        s.redirect_pc = $urandom();
        s.rs1         = 5'($urandom_range(0, 3));
        s.rs2         = 5'($urandom_range(0, 3));
        s.use1        = 1'($urandom_range(0, 1));
        s.use2        = 1'($urandom_range(0, 1));
        s.ex_valid    = 1'($urandom_range(0, 1));
        s.ex_we       = 1'($urandom_range(0, 1));
        s.ex_load     = 1'($urandom_range(0, 1));
        s.ex_rd       = 5'($urandom_range(0, 3));
        s.wb_valid    = 1'($urandom_range(0, 1));
        s.wb_we       = 1'($urandom_range(0, 1));
        s.wb_rd       = 5'($urandom_range(0, 3));
        s.wb_data     = $urandom();
        s.rs1_raw     = $urandom();
        s.rs2_raw     = $urandom();
        return s;
    endfunction

    initial begin
        stim_t idle, s;
        int    guard;
        idle = '0;
        idle.rs1_raw = 32'hCAFE_0001;
        idle.rs2_raw = 32'hCAFE_0002;
        model_reset();
        repeat (3) applyStimulus('0, 1'b0);
        repeat (4) applyStimulus(idle, 1'b1);

        // Redirect to 0x103 issued while the PC sits at 0x20.
        guard = 0;
        while (m_pc != 32'h20 && guard < 40) begin
            applyStimulus(idle, 1'b1);
            guard++;
        end
        s = idle; s.redirect = 1'b1; s.redirect_pc = 32'h103;
        applyStimulus(s, 1'b1);
        repeat (4) applyStimulus(idle, 1'b1);

        // lw x5 in execute, add x6,x5,x1 in decode, then the bubble reaches execute.
        s = idle; s.ex_valid = 1'b1; s.ex_we = 1'b1; s.ex_load = 1'b1; s.ex_rd = 5'd5;
        s.rs1 = 5'd5; s.rs2 = 5'd1; s.use1 = 1'b1; s.use2 = 1'b1;
        applyStimulus(s, 1'b1);
        s.ex_valid = 1'b0;
        applyStimulus(s, 1'b1);
        repeat (2) applyStimulus(idle, 1'b1);

        // Same shape targeting x0.
        s = idle; s.ex_valid = 1'b1; s.ex_we = 1'b1; s.ex_load = 1'b1; s.ex_rd = 5'd0;
        s.rs1 = 5'd0; s.use1 = 1'b1;
        applyStimulus(s, 1'b1);
        repeat (2) applyStimulus(idle, 1'b1);

        // Forwarding priority for x7.
        s = idle; s.wb_valid = 1'b1; s.wb_we = 1'b1; s.wb_rd = 5'd7; s.wb_data = 32'h55;
        applyStimulus(s, 1'b1);
        s.wb_data = 32'hAA; s.rs1 = 5'd7; s.rs1_raw = 32'hDEAD_BEEF;
        applyStimulus(s, 1'b1);
        s = idle; s.wb_valid = 1'b1; s.wb_we = 1'b1; s.wb_rd = 5'd7; s.wb_data = 32'h11;
        applyStimulus(s, 1'b1);
        s.wb_rd = 5'd9; s.wb_data = 32'h99;
        applyStimulus(s, 1'b1);
        s = idle; s.rs1 = 5'd7; s.rs1_raw = 32'h1234_5678;
        applyStimulus(s, 1'b1);

        // x0 always reads raw even with a live rd=0 write-back.
        s = idle; s.wb_valid = 1'b1; s.wb_we = 1'b1; s.wb_rd = 5'd0; s.wb_data = 32'h77;
        s.rs1 = 5'd0; s.rs1_raw = 32'h0000_1234;
        applyStimulus(s, 1'b1);
        repeat (2) applyStimulus(idle, 1'b1);

        // Redirect coincident with a load-use hit.
        s = idle; s.ex_valid = 1'b1; s.ex_we = 1'b1; s.ex_load = 1'b1; s.ex_rd = 5'd5;
        s.rs1 = 5'd5; s.use1 = 1'b1; s.redirect = 1'b1; s.redirect_pc = 32'h200;
        applyStimulus(s, 1'b1);
        repeat (3) applyStimulus(idle, 1'b1);

        // PC wrap at the top of the address space.
        s = idle; s.redirect = 1'b1; s.redirect_pc = 32'hFFFF_FFFE;
        applyStimulus(s, 1'b1);
        repeat (2) applyStimulus(idle, 1'b1);

        // Reset while a flush is in progress.
        s = idle; s.redirect = 1'b1; s.redirect_pc = 32'h400;
        applyStimulus(s, 1'b1);
        applyStimulus(idle, 1'b1);
        repeat (2) applyStimulus('0, 1'b0);
        repeat (3) applyStimulus(idle, 1'b1);

        // add x3 then sub x4,x3 walking through execute and write-back.
        s = idle; s.ex_valid = 1'b1; s.ex_we = 1'b1; s.ex_rd = 5'd3; s.rs1 = 5'd3; s.use1 = 1'b1;
        applyStimulus(s, 1'b1);
        s = idle; s.wb_valid = 1'b1; s.wb_we = 1'b1; s.wb_rd = 5'd3; s.wb_data = 32'h33;
        s.rs1 = 5'd3; s.use1 = 1'b1;
        applyStimulus(s, 1'b1);
        s = idle; s.rs1 = 5'd3; s.use1 = 1'b1;
        repeat (4) applyStimulus(s, 1'b1);

        for (int n = 0; n < 400; n++) applyStimulus(rnd_stim(), 1'b1);
        repeat (2) applyStimulus(idle, 1'b1);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge p_clk);
            guard++;
        end
        #1;
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
